alu_key_sequencer: RTL
======================

// Module: alu_key_sequencer
// PURPOSE
//  Sequences the keypad -> register-bank -> ALU datapath of the calculator top level.
//  Consumes one-cycle key events from the keypad encoder and enters operand A, operator and operand B.
//  On the execute key it drives the register-bank read/write ports and the ALU select.
//  It then writes the ALU result back to the bank and holds it for the 7-segment output.
// PARAMETERS
//  DATA_W     8   register-bank/ALU data width
//  ADDR_W     2   register-bank address width
//  ADDR_A     0   bank address holding operand A
//  ADDR_B     1   bank address holding operand B
//  ADDR_R     2   bank address receiving the result
//  EXEC_WAIT  2   cycles allowed for bank read + ALU settle (>=1)
// PORTS
//  clk           in   1       clock, all logic on rising edge
//  reset         in   1       synchronous, active-high reset
//  key_valid     in   1       one-cycle strobe: key_code valid this cycle
//  key_code      in   4       keypad hex code: 0-9 digit, A-D op, E clear, F execute
//  alu_result    in   DATA_W  ALU output (from REG_A op REG_B)
//  alu_carry     in   1       ALU carry-out
//  alu_zero      in   1       ALU zero flag
//  rd_addr_a     out  ADDR_W  bank read port A address
//  rd_addr_b     out  ADDR_W  bank read port B address
//  wr_en         out  1       bank write enable, one-cycle pulse
//  wr_addr       out  ADDR_W  bank write address
//  wr_data       out  DATA_W  bank write data
//  alu_op        out  2       ALU select
//  result        out  DATA_W  last result, held until next WB or reset
//  result_carry  out  1       carry captured with result
//  result_zero   out  1       zero flag captured with result
//  done          out  1       one-cycle pulse in the WB cycle
//  busy          out  1       high in EXEC and WB
// BEHAVIOUR
//  All outputs registered.
//  Reset values: outputs 0 except rd_addr_a=ADDR_A, rd_addr_b=ADDR_B. State=S_A, exec counter 0.
//  States: S_A -> S_OP -> S_B -> S_EQ -> EXEC -> WB -> S_A.
//  Keys are evaluated only when key_valid=1. Unlisted keys in a state are ignored (no state change).
//  S_A  : digit d -> wr_en=1, wr_addr=ADDR_A, wr_data={0,d} next cycle; go S_OP.
//  S_OP : A/B/C/D -> latch alu_op=0/1/2/3; go S_B.
//  S_B  : digit d -> write {0,d} to ADDR_B; go S_EQ.
//  S_EQ : F -> go EXEC, clear exec counter, busy=1.
//  Key E in S_A/S_OP/S_B/S_EQ: go S_A.
//    - alu_op is not cleared by E.
//    - result, result_carry and result_zero are kept.
//    - No write is issued.
//  EXEC:
//    - rd_addr_a=ADDR_A, rd_addr_b=ADDR_B, alu_op stable.
//    - Counter counts 0..EXEC_WAIT-1.
//    - In the last EXEC cycle, sample alu_result, alu_carry and alu_zero.
//  WB (one cycle):
//    - wr_en=1, wr_addr=ADDR_R, wr_data=sampled result.
//    - result, result_carry and result_zero updated.
//    - done=1.
//    - Next state S_A, busy=0.
//  Latency: F accepted at edge k -> done high during cycle k+EXEC_WAIT+1.
//  Key events (including E) during EXEC/WB are dropped. They are not queued.
//  wr_en never asserts on two consecutive cycles. At most one write per accepted key or WB.
//  Reset mid-EXEC/WB: no WB write, done stays 0, result cleared to 0.
//  Result is truncated to DATA_W. Carry comes only from alu_carry.
// TESTING
//  1. keys 3,A,4,F; alu_result=0x07 -> writes 0x03@0, 0x04@1, 0x07@2; result=0x07; done one cycle.
//  2. keys 5,B,5,F; alu_result=0x00, alu_zero=1 -> result_zero=1, alu_op=1 held during EXEC.
//  3. keys 7,E,2,C,9,F -> writes 0x07@0, 0x02@0, 0x09@1; alu_op=2; E issues no write.
//  4. keys A,F,3 in S_A -> only 0x03@0 written, state S_OP; keys during busy -> no wr_en, no state change.
//  5. reset asserted in cycle k+1 of EXEC -> no wr_en to ADDR_R, done=0, result=0, state S_A.
//  6. EXEC_WAIT=1 vs 4: F at edge k -> done at cycle k+2 / k+5 respectively.

Source files
------------

// File: rtl/alu_key_sequencer_if.sv
// Keypad / register-bank / ALU bus of the calculator sequencer.
//   master : keypad encoder + ALU side (drives keys and ALU flags)
//   slave  : alu_key_sequencer (drives bank ports, ALU select, result)
// Signals: key_valid/key_code (key strobe), alu_result/alu_carry/alu_zero
// (ALU outputs), rd_addr_a/rd_addr_b (bank read), wr_en/wr_addr/wr_data
// (bank write), alu_op, result/result_carry/result_zero, done, busy.
interface alu_key_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              key_valid;
  logic [3:0]        key_code;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] result;
  logic              result_carry;
  logic              result_zero;
  logic              done;
  logic              busy;

  modport master (
    output key_valid, key_code, alu_result, alu_carry, alu_zero,
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, alu_op,
           result, result_carry, result_zero, done, busy
  );

  modport slave (
    input  key_valid, key_code, alu_result, alu_carry, alu_zero,
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, alu_op,
           result, result_carry, result_zero, done, busy
  );
endinterface

// File: rtl/alu_key_sequencer.sv
// alu_key_sequencer: enters operand A, operator and operand B from one-cycle
// key strobes, writes operands to the register bank, and on the execute key
// waits EXEC_WAIT cycles for bank read + ALU settle, then writes the ALU
// result back to ADDR_R and holds it for display.
// Ports: clk, reset (sync, active-high), bus (slave modport of
// alu_key_sequencer_if carrying keys, ALU flags, bank ports and result).
// All outputs are registered.
module alu_key_sequencer #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 2,
  parameter int ADDR_A    = 0,
  parameter int ADDR_B    = 1,
  parameter int ADDR_R    = 2,
  parameter int EXEC_WAIT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_key_sequencer_if.slave   bus
);
  // Wide enough that EXEC_WAIT=1 still yields a 1-bit counter.
  localparam int CNT_W = $clog2(EXEC_WAIT + 1);

  typedef enum logic [2:0] {S_A, S_OP, S_B, S_EQ, S_EXEC, S_WB} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_b_q;

  logic key_digit, key_op, key_clr, key_exe, exec_last;
  logic [DATA_W-1:0] digit_ext;

  assign key_digit = bus.key_valid && (bus.key_code <= 4'd9);
  assign key_op    = bus.key_valid && (bus.key_code >= 4'hA) && (bus.key_code <= 4'hD);
  assign key_clr   = bus.key_valid && (bus.key_code == 4'hE);
  assign key_exe   = bus.key_valid && (bus.key_code == 4'hF);
  assign exec_last = (cnt_q == CNT_W'(EXEC_WAIT - 1));
  assign digit_ext = {{(DATA_W-4){1'b0}}, bus.key_code};

  // State register (with all registered outputs)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_A;
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      alu_op_q    <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      rd_addr_a_q <= ADDR_W'(ADDR_A);
      rd_addr_b_q <= ADDR_W'(ADDR_B);
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      alu_op_q    <= alu_op_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      rd_addr_a_q <= ADDR_W'(ADDR_A);
      rd_addr_b_q <= ADDR_W'(ADDR_B);
    end
  end

  // Next state; keys outside S_A..S_EQ are simply never looked at.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_A:  if (key_digit) state_d = S_OP;
      S_OP: if (key_op) state_d = S_B; else if (key_clr) state_d = S_A;
      S_B:  if (key_digit) state_d = S_EQ; else if (key_clr) state_d = S_A;
      S_EQ: begin
        if (key_exe) begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end else if (key_clr) begin
          state_d = S_A;
        end
      end
      S_EXEC: begin
        if (exec_last) state_d = S_WB;
        else           cnt_d   = cnt_q + 1'b1;
      end
      S_WB:    state_d = S_A;
      default: state_d = S_A;
    endcase
  end

  // Output next values. The ALU is sampled on the edge leaving the last
  // EXEC cycle so the write-back and result show up together in WB.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    alu_op_d  = alu_op_q;
    result_d  = result_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
    busy_d    = (state_d == S_EXEC) || (state_d == S_WB);
    case (state_q)
      S_A: if (key_digit) begin
        wr_en_d   = 1'b1;
        wr_addr_d = ADDR_W'(ADDR_A);
        wr_data_d = digit_ext;
      end
      // A/B/C/D -> 0/1/2/3
      S_OP: if (key_op) alu_op_d = bus.key_code[1:0] - 2'd2;
      S_B: if (key_digit) begin
        wr_en_d   = 1'b1;
        wr_addr_d = ADDR_W'(ADDR_B);
        wr_data_d = digit_ext;
      end
      S_EXEC: if (exec_last) begin
        wr_en_d   = 1'b1;
        wr_addr_d = ADDR_W'(ADDR_R);
        wr_data_d = bus.alu_result;
        result_d  = bus.alu_result;
        carry_d   = bus.alu_carry;
        zero_d    = bus.alu_zero;
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.rd_addr_a    = rd_addr_a_q;
  assign bus.rd_addr_b    = rd_addr_b_q;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.result       = result_q;
  assign bus.result_carry = carry_q;
  assign bus.result_zero  = zero_q;
  assign bus.done         = done_q;
  assign bus.busy         = busy_q;
endmodule
